// File: rtl/work_steal_controller.sv
// Work-steal controller: watches per-PU queue occupancy and idle flags,
// pairs one idle thief with the most loaded victim, and opens a bounded
// steal window on the crossbar followed by a fixed cooldown.
module work_steal_controller #(
    parameter int NUM_PU        = 16,
    parameter int OCC_BITS      = 8,
    parameter int STEAL_THRESH  = 4,
    parameter int MAX_XFER      = 8,
    parameter int STEAL_TIMEOUT = 64,
    parameter int COOLDOWN      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NUM_PU*OCC_BITS-1:0]   pu_occ,
    input  logic [NUM_PU-1:0]            pu_idle,
    input  logic                         xfer_fire,
    output logic                         steal_en,
    output logic [$clog2(NUM_PU)-1:0]    steal_from,
    output logic [$clog2(NUM_PU)-1:0]    steal_to,
    output logic                         busy,
    output logic [15:0]                  steal_count
);

    localparam int IDX_W  = $clog2(NUM_PU);
    localparam int XFER_W = $clog2(MAX_XFER + 1);
    localparam int TMR_W  = $clog2(STEAL_TIMEOUT + 1);
    localparam int COOL_W = $clog2(COOLDOWN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        STEAL = 2'd2,
        COOL  = 2'd3
    } state_t;

    state_t              state_r, next_state_s;
    logic [XFER_W-1:0]   xfer_r;
    logic [TMR_W-1:0]    tmr_r;
    logic [COOL_W-1:0]   cool_r;

    logic                steal_en_r, steal_en_s;
    logic                busy_r, busy_s;
    logic [IDX_W-1:0]    from_r, from_s, to_r, to_s;
    logic [15:0]         count_r, count_s;

    logic                thief_found_s, vic_found_s, candidate_s;
    logic [IDX_W-1:0]    thief_idx_s, vic_idx_s;
    logic [OCC_BITS-1:0] vic_occ_s, cur_vic_occ_s, cur_thief_occ_s;
    logic                exit_s, start_s;

    // Thief search: lowest-index PU that is idle with an empty queue.
    always_comb begin
        thief_found_s = 1'b0;
        thief_idx_s   = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_PU; k++) begin
            if (!thief_found_s && pu_idle[k] &&
                (pu_occ[k*OCC_BITS +: OCC_BITS] == {OCC_BITS{1'b0}})) begin
                thief_found_s = 1'b1;
                thief_idx_s   = IDX_W'(k);
            end else begin
                thief_found_s = thief_found_s;
            end
        end
    end

    // Victim search: maximum occupancy excluding the thief; strict compare keeps ties on the lowest index.
    always_comb begin
        vic_found_s = 1'b0;
        vic_idx_s   = {IDX_W{1'b0}};
        vic_occ_s   = {OCC_BITS{1'b0}};
        for (int k = 0; k < NUM_PU; k++) begin
            if ((IDX_W'(k) != thief_idx_s) &&
                (!vic_found_s || (pu_occ[k*OCC_BITS +: OCC_BITS] > vic_occ_s))) begin
                vic_found_s = 1'b1;
                vic_idx_s   = IDX_W'(k);
                vic_occ_s   = pu_occ[k*OCC_BITS +: OCC_BITS];
            end else begin
                vic_found_s = vic_found_s;
            end
        end
    end

    // Window-close conditions, evaluated against the latched pairing.
    always_comb begin
        candidate_s     = thief_found_s && vic_found_s &&
                          (vic_occ_s >= OCC_BITS'(STEAL_THRESH));
        cur_vic_occ_s   = pu_occ[int'(from_r)*OCC_BITS +: OCC_BITS];
        cur_thief_occ_s = pu_occ[int'(to_r)*OCC_BITS +: OCC_BITS];
        exit_s = (xfer_fire && (xfer_r == XFER_W'(MAX_XFER - 1))) ||
                 (tmr_r == TMR_W'(STEAL_TIMEOUT - 1)) ||
                 (cur_vic_occ_s == {OCC_BITS{1'b0}}) ||
                 (!pu_idle[to_r] && (cur_thief_occ_s != {OCC_BITS{1'b0}}));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; dropping enable in STEAL aborts straight to IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = enable ? SCAN : IDLE;
            SCAN: begin
                if (!enable)          next_state_s = IDLE;
                else if (candidate_s) next_state_s = STEAL;
                else                  next_state_s = SCAN;
            end
            STEAL: begin
                if (!enable)     next_state_s = IDLE;
                else if (exit_s) next_state_s = COOL;
                else             next_state_s = STEAL;
            end
            COOL: begin
                if (cool_r == COOL_W'(COOLDOWN - 1)) next_state_s = enable ? SCAN : IDLE;
                else                                 next_state_s = COOL;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Window and cooldown counters; cleared on entry to their state.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_r <= {XFER_W{1'b0}};
            tmr_r  <= {TMR_W{1'b0}};
            cool_r <= {COOL_W{1'b0}};
        end else begin
            if (start_s) begin
                xfer_r <= {XFER_W{1'b0}};
                tmr_r  <= {TMR_W{1'b0}};
            end else if (state_r == STEAL) begin
                tmr_r  <= tmr_r + TMR_W'(1);
                xfer_r <= xfer_fire ? (xfer_r + XFER_W'(1)) : xfer_r;
            end else begin
                xfer_r <= xfer_r;
                tmr_r  <= tmr_r;
            end
            if (state_r != COOL) begin
                cool_r <= {COOL_W{1'b0}};
            end else begin
                cool_r <= cool_r + COOL_W'(1);
            end
        end
    end

    // Output next-values: pairing latches only on SCAN->STEAL; busy reflects the current state one cycle later.
    always_comb begin
        start_s    = (state_r == SCAN) && (next_state_s == STEAL);
        steal_en_s = (next_state_s == STEAL);
        busy_s     = (state_r != IDLE);
        if (start_s) begin
            from_s  = vic_idx_s;
            to_s    = thief_idx_s;
            count_s = (count_r == 16'hFFFF) ? count_r : (count_r + 16'd1);
        end else begin
            from_s  = from_r;
            to_s    = to_r;
            count_s = count_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            steal_en_r <= 1'b0;
            busy_r     <= 1'b0;
            from_r     <= {IDX_W{1'b0}};
            to_r       <= {IDX_W{1'b0}};
            count_r    <= 16'd0;
        end else begin
            steal_en_r <= steal_en_s;
            busy_r     <= busy_s;
            from_r     <= from_s;
            to_r       <= to_s;
            count_r    <= count_s;
        end
    end

    assign steal_en    = steal_en_r;
    assign busy        = busy_r;
    assign steal_from  = from_r;
    assign steal_to    = to_r;
    assign steal_count = count_r;

endmodule

// File: tb/tb_work_steal_controller.sv
// Directed bench for work_steal_controller with NUM_PU=4, OCC_BITS=8.
module tb_work_steal_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] pu_occ;
    logic [3:0]  pu_idle;
    logic        xfer_fire;
    logic        steal_en;
    logic [1:0]  steal_from;
    logic [1:0]  steal_to;
    logic        busy;
    logic [15:0] steal_count;

    int n_pass  = 0;
    int n_total = 0;

    work_steal_controller #(
        .NUM_PU(4), .OCC_BITS(8), .STEAL_THRESH(4),
        .MAX_XFER(8), .STEAL_TIMEOUT(64), .COOLDOWN(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pu_occ(pu_occ),
        .pu_idle(pu_idle), .xfer_fire(xfer_fire), .steal_en(steal_en),
        .steal_from(steal_from), .steal_to(steal_to), .busy(busy),
        .steal_count(steal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] occ;   // PU0 in the low byte
        logic [3:0]  idle;
        int          en;
        int          from;
        int          to;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Drive at a negedge; one posedge with rst=1 lands before returning.
    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; xfer_fire = 1'b0;
        pu_occ = 32'd0; pu_idle = 4'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts consecutive negedge samples with steal_en high, from the current one.
    task automatic count_en_high(output int n);
        n = 0;
        while (steal_en && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Apply pairing inputs and enable, then sample two cycles later (SCAN then STEAL).
    task automatic start_scan(input logic [31:0] occ, input logic [3:0] idle);
        pu_occ = occ; pu_idle = idle; enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    int n;

    initial begin
        vecs[0] = '{"basic",       {8'd1, 8'd2, 8'd9, 8'd0}, 4'b0001, 1, 1, 0};
        vecs[1] = '{"below_thr",   {8'd3, 8'd3, 8'd3, 8'd0}, 4'b0001, 0, 0, 0};
        vecs[2] = '{"tie_break",   {8'd6, 8'd6, 8'd0, 8'd0}, 4'b0011, 1, 2, 0};
        vecs[3] = '{"n_minus_1",   {8'd5, 8'd0, 8'd0, 8'd0}, 4'b0111, 1, 3, 0};
        vecs[4] = '{"thief_pu1",   {8'd4, 8'd4, 8'd0, 8'd7}, 4'b0010, 1, 0, 1};
        vecs[5] = '{"idle_nonempty",{8'd9, 8'd9, 8'd0, 8'd2}, 4'b0011, 1, 2, 1};
        vecs[6] = '{"exact_thr",   {8'd0, 8'd0, 8'd4, 8'd0}, 4'b0001, 1, 1, 0};
        vecs[7] = '{"no_thief",    {8'd9, 8'd9, 8'd9, 8'd0}, 4'b0000, 0, 0, 0};

        @(negedge clk);
        do_reset();
        check("reset_en",    int'(steal_en), 0);
        check("reset_busy",  int'(busy), 0);
        check("reset_from",  int'(steal_from), 0);
        check("reset_to",    int'(steal_to), 0);
        check("reset_count", int'(steal_count), 0);

        // Decision table
        for (int i = 0; i < 8; i++) begin
            do_reset();
            start_scan(vecs[i].occ, vecs[i].idle);
            check({vecs[i].name, "_en"},    int'(steal_en), vecs[i].en);
            check({vecs[i].name, "_from"},  int'(steal_from), vecs[i].from);
            check({vecs[i].name, "_to"},    int'(steal_to), vecs[i].to);
            check({vecs[i].name, "_count"}, int'(steal_count), vecs[i].en);
            check({vecs[i].name, "_busy"},  int'(busy), 1);
        end

        // MAX_XFER exit, then 4 COOL cycles plus one SCAN cycle before reopening
        do_reset();
        start_scan({8'd1, 8'd2, 8'd9, 8'd0}, 4'b0001);
        xfer_fire = 1'b1;
        count_en_high(n);
        check("xfer_window_len", n, 8);
        xfer_fire = 1'b0;
        n = 0;
        while (!steal_en && n < 50) begin
            check("cool_busy", int'(busy), 1);
            n++;
            @(negedge clk);
        end
        check("cool_low_len", n, 5);
        check("cool_reopen_count", int'(steal_count), 2);

        // Timeout with no transfers
        do_reset();
        start_scan({8'd1, 8'd2, 8'd9, 8'd0}, 4'b0001);
        count_en_high(n);
        check("timeout_len", n, 64);

        // Abort by dropping enable mid-window
        do_reset();
        start_scan({8'd1, 8'd2, 8'd9, 8'd0}, 4'b0001);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_en",   int'(steal_en), 0);
        check("abort_busy1", int'(busy), 1);
        check("abort_from", int'(steal_from), 1);
        @(negedge clk);
        check("abort_busy0", int'(busy), 0);

        // Thief leaves idle: only closes once its queue is non-empty
        do_reset();
        start_scan({8'd1, 8'd2, 8'd9, 8'd0}, 4'b0001);
        pu_idle = 4'b0000;
        @(negedge clk);
        check("thief_busy_empty_en", int'(steal_en), 1);
        pu_occ = {8'd1, 8'd2, 8'd9, 8'd3};
        @(negedge clk);
        check("thief_busy_en", int'(steal_en), 0);
        check("thief_busy_to", int'(steal_to), 0);

        // Victim empties; enable dropped in COOL still runs the full countdown
        do_reset();
        start_scan({8'd1, 8'd2, 8'd9, 8'd0}, 4'b0001);
        pu_occ = {8'd1, 8'd2, 8'd0, 8'd0};
        @(negedge clk);
        check("vic_empty_en", int'(steal_en), 0);
        check("vic_empty_from", int'(steal_from), 1);
        enable = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("cool_then_idle_busy_len", n, 5);
        check("cool_then_idle_en", int'(steal_en), 0);

        // Reset mid-window
        do_reset();
        start_scan({8'd1, 8'd2, 8'd9, 8'd0}, 4'b0001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_en",    int'(steal_en), 0);
        check("rst_mid_busy",  int'(busy), 0);
        check("rst_mid_from",  int'(steal_from), 0);
        check("rst_mid_to",    int'(steal_to), 0);
        check("rst_mid_count", int'(steal_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
